// File: rtl/poly_arb_pkg.sv
// Shared types and constants for the two-client polynomial evaluator arbiter.
// Imported by the round-robin selector and the arbiter top.
package poly_arb_pkg;
    localparam int NUM_CLIENTS = 2;
    localparam int CLIENT_W    = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BUSY   = 2'd2
    } arb_state_e;

    function automatic logic [NUM_CLIENTS-1:0] client_onehot(input logic [CLIENT_W-1:0] idx);
        client_onehot = '0;
        client_onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/poly_arb_rr_select.sv
// Combinational round-robin pick: first requesting client at or after (last+1).
// Purely combinational; the caller registers the chosen owner.
module poly_arb_rr_select
    import poly_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] requests,
    input  logic [CLIENT_W-1:0]    last,
    output logic [CLIENT_W-1:0]    owner,
    output logic                   valid
);
    logic [CLIENT_W-1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        owner = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            cand = CLIENT_W'((int'(last) + 1 + k) % NUM_CLIENTS);
            if (requests[cand]) begin
                owner = cand;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/poly_eval_arbiter.sv
// Shares one polynomial evaluator between two clients: one instruction per grant,
// result written back to the owner, with a BUSY watchdog that flags a sticky error.
//
// Handshake: every FIFO port is empty/full + read/write-enable; a transfer happens on
// a cycle where the enable is high and the flag is clear; enables are only ever driven
// toward the current owner and are forced low while reset is high.
module poly_eval_arbiter
    import poly_arb_pkg::*;
#(
    parameter int INSTR_WIDTH = 21,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2*INSTR_WIDTH-1:0]   instr_in,
    input  logic [1:0]                 instr_empty,
    output logic [1:0]                 instr_read,
    input  logic [2*DATA_WIDTH-1:0]    data_in,
    input  logic [1:0]                 data_empty,
    output logic [1:0]                 data_read,
    input  logic [1:0]                 res_full,
    input  logic [1:0]                 stat_full,
    output logic [1:0]                 res_write,
    output logic [INSTR_WIDTH-1:0]     ev_instruction,
    output logic                       ev_empty_instruction,
    input  logic                       ev_read_instruction,
    output logic [DATA_WIDTH-1:0]      ev_data,
    output logic                       ev_empty_data,
    input  logic                       ev_read_data,
    input  logic                       ev_write_result,
    output logic                       ev_full_result,
    output logic                       ev_full_status,
    output logic [1:0]                 grant,
    output logic [1:0]                 timeout_err,
    output logic [1:0]                 dbg_state
);
    localparam int              CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_e                state_q, state_d;
    logic [CLIENT_W-1:0]       owner_q, owner_d;
    logic [CLIENT_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0]    terr_q, terr_d;

    logic [CLIENT_W-1:0]       rr_owner;
    logic                      rr_valid;
    logic [NUM_CLIENTS-1:0]    owner_oh;
    logic                      write_ok;

    poly_arb_rr_select u_rr (
        .requests (~instr_empty),
        .last     (last_q),
        .owner    (rr_owner),
        .valid    (rr_valid)
    );

    assign owner_oh    = client_onehot(owner_q);
    // Result and status share one write enable, so both FIFOs must have room.
    assign write_ok    = ev_write_result & ~res_full[owner_q] & ~stat_full[owner_q];
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d              = state_q;
        owner_d              = owner_q;
        last_d               = last_q;
        cnt_d                = cnt_q;
        terr_d               = terr_q;
        ev_instruction       = '0;
        ev_empty_instruction = 1'b1;
        ev_data              = '0;
        ev_empty_data        = 1'b1;
        ev_full_result       = 1'b1;
        ev_full_status       = 1'b1;
        instr_read           = '0;
        data_read            = '0;
        res_write            = '0;
        grant                = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    owner_d = rr_owner;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                grant                = owner_oh;
                ev_instruction       = instr_in[int'(owner_q)*INSTR_WIDTH +: INSTR_WIDTH];
                ev_empty_instruction = instr_empty[owner_q];
                ev_data              = data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
                ev_empty_data        = data_empty[owner_q];
                ev_full_result       = res_full[owner_q];
                ev_full_status       = stat_full[owner_q];
                instr_read           = ev_read_instruction ? owner_oh : '0;
                data_read            = ev_read_data ? owner_oh : '0;
                if (ev_read_instruction) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                grant          = owner_oh;
                ev_data        = data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
                ev_empty_data  = data_empty[owner_q];
                ev_full_result = res_full[owner_q];
                ev_full_status = stat_full[owner_q];
                data_read      = ev_read_data ? owner_oh : '0;
                // A result on the terminal-count cycle takes priority over the timeout.
                if (write_ok) begin
                    res_write = owner_oh;
                    last_d    = owner_q;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    terr_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    state_d         = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            instr_read = '0;
            data_read  = '0;
            res_write  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= CLIENT_W'(1);
            cnt_q   <= '0;
            terr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed bench for poly_eval_arbiter (TIMEOUT=16): single-client flow, alternation,
// watchdog, back-pressure, mid-BUSY reset and result-on-terminal-count.
module tb_poly_eval_arbiter;
  import poly_arb_pkg::*;

  localparam int IW = 21;
  localparam int DW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [2*IW-1:0] instr_in;
  logic [1:0]      instr_empty;
  logic [1:0]      instr_read;
  logic [2*DW-1:0] data_in;
  logic [1:0]      data_empty;
  logic [1:0]      data_read;
  logic [1:0]      res_full;
  logic [1:0]      stat_full;
  logic [1:0]      res_write;
  logic [IW-1:0]   ev_instruction;
  logic            ev_empty_instruction;
  logic            ev_read_instruction;
  logic [DW-1:0]   ev_data;
  logic            ev_empty_data;
  logic            ev_read_data;
  logic            ev_write_result;
  logic            ev_full_result;
  logic            ev_full_status;
  logic [1:0]      grant;
  logic [1:0]      timeout_err;
  logic [1:0]      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  poly_eval_arbiter #(.INSTR_WIDTH(IW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .instr_in(instr_in), .instr_empty(instr_empty), .instr_read(instr_read),
    .data_in(data_in), .data_empty(data_empty), .data_read(data_read),
    .res_full(res_full), .stat_full(stat_full), .res_write(res_write),
    .ev_instruction(ev_instruction), .ev_empty_instruction(ev_empty_instruction),
    .ev_read_instruction(ev_read_instruction),
    .ev_data(ev_data), .ev_empty_data(ev_empty_data), .ev_read_data(ev_read_data),
    .ev_write_result(ev_write_result), .ev_full_result(ev_full_result),
    .ev_full_status(ev_full_status),
    .grant(grant), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr_in = '0; instr_empty = 2'b11;
    data_in = '0; data_empty = 2'b11;
    res_full = 2'b00; stat_full = 2'b00;
    ev_read_instruction = 1'b0; ev_read_data = 1'b0; ev_write_result = 1'b0;
    step(); step();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_ev_empty_i", 32'(ev_empty_instruction), 32'h1);
    chk("rst_ev_full_r", 32'(ev_full_result), 32'h1);
    chk("rst_terr", 32'(timeout_err), 32'h0);

    // Only client 0 requests; result after 5 BUSY cycles
    instr_in = {21'h0AAAAA, 21'h012345};
    data_in = {16'hBBBB, 16'h1111};
    instr_empty = 2'b10; data_empty = 2'b10;
    step();
    chk("c0_grant", 32'(grant), 32'h1);
    chk("c0_state", 32'(dbg_state), 32'(ST_ACTIVE));
    chk("c0_ev_instr", 32'(ev_instruction), 32'h012345);
    chk("c0_ev_empty_i", 32'(ev_empty_instruction), 32'h0);
    chk("c0_ev_data", 32'(ev_data), 32'h1111);
    ev_read_instruction = 1'b1; ev_read_data = 1'b1;
    settle();
    chk("c0_instr_read", 32'(instr_read), 32'h1);
    chk("c0_data_read", 32'(data_read), 32'h1);
    step();
    ev_read_instruction = 1'b0; ev_read_data = 1'b0; instr_empty = 2'b11;
    settle();
    chk("c0_busy_state", 32'(dbg_state), 32'(ST_BUSY));
    chk("c0_busy_empty_i", 32'(ev_empty_instruction), 32'h1);
    chk("c0_busy_instr_read", 32'(instr_read), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("c0_wait_res_write", 32'(res_write), 32'h0);
    end
    ev_write_result = 1'b1;
    settle();
    chk("c0_res_write", 32'(res_write), 32'h1);
    step();
    ev_write_result = 1'b0;
    settle();
    chk("c0_done_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("c0_done_grant", 32'(grant), 32'h0);
    chk("c0_done_res_write", 32'(res_write), 32'h0);

    // Both clients always requesting: alternation 0,1,0,1 from reset
    reset = 1'b1; step(); reset = 1'b0;
    instr_empty = 2'b00;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("rr_idle_grant", 32'(grant), 32'h0);
      step();
      chk("rr_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_ev_instr", 32'(ev_instruction), (i % 2 == 0) ? 32'h012345 : 32'h0AAAAA);
      ev_read_instruction = 1'b1;
      settle();
      chk("rr_instr_read", 32'(instr_read), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      ev_read_instruction = 1'b0; ev_write_result = 1'b1;
      settle();
      chk("rr_res_write", 32'(res_write), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      ev_write_result = 1'b0;
      settle();
    end

    // Watchdog: client 0 reads, never writes; 16 BUSY cycles then IDLE
    instr_empty = 2'b10;
    step();
    chk("to_grant", 32'(grant), 32'h1);
    ev_read_instruction = 1'b1;
    step();
    ev_read_instruction = 1'b0; instr_empty = 2'b11;
    settle();
    chk("to_busy_first", 32'(dbg_state), 32'(ST_BUSY));
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_busy_hold", 32'(dbg_state), 32'(ST_BUSY));
      chk("to_err_clear", 32'(timeout_err), 32'h0);
    end
    step();
    chk("to_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_err_set", 32'(timeout_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_err_sticky", 32'(timeout_err), 32'h1);
    end

    // Back-pressure: owner 1 result FIFO full holds off the write
    instr_empty = 2'b01;
    step();
    chk("bp_grant", 32'(grant), 32'h2);
    ev_read_instruction = 1'b1;
    step();
    ev_read_instruction = 1'b0; instr_empty = 2'b11;
    res_full = 2'b10; stat_full = 2'b10; ev_write_result = 1'b1;
    settle();
    chk("bp_full_result", 32'(ev_full_result), 32'h1);
    chk("bp_full_status", 32'(ev_full_status), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_write", 32'(res_write), 32'h0);
      step();
    end
    res_full = 2'b00; stat_full = 2'b00;
    settle();
    chk("bp_full_clear", 32'(ev_full_result), 32'h0);
    chk("bp_res_write", 32'(res_write), 32'h2);
    step();
    chk("bp_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("bp_ignored_idle_write", 32'(res_write), 32'h0);
    chk("bp_err_kept", 32'(timeout_err), 32'h1);
    ev_write_result = 1'b0;

    // Reset while BUSY as owner 1
    instr_empty = 2'b01;
    step();
    ev_read_instruction = 1'b1;
    step();
    ev_read_instruction = 1'b0; instr_empty = 2'b11;
    settle();
    chk("rb_busy_grant", 32'(grant), 32'h2);
    reset = 1'b1; ev_write_result = 1'b1;
    step();
    reset = 1'b0; ev_write_result = 1'b0;
    settle();
    chk("rb_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rb_grant", 32'(grant), 32'h0);
    chk("rb_terr", 32'(timeout_err), 32'h0);
    chk("rb_ev_empty_i", 32'(ev_empty_instruction), 32'h1);
    chk("rb_ev_data", 32'(ev_data), 32'h0);
    chk("rb_res_write", 32'(res_write), 32'h0);
    instr_empty = 2'b00;
    step();
    chk("rb_next_grant", 32'(grant), 32'h1);

    // Result on terminal count (counter = 15) wins over timeout
    ev_read_instruction = 1'b1;
    step();
    ev_read_instruction = 1'b0; instr_empty = 2'b11;
    for (int i = 0; i < 15; i++) step();
    chk("tc_still_busy", 32'(dbg_state), 32'(ST_BUSY));
    ev_write_result = 1'b1;
    settle();
    chk("tc_res_write", 32'(res_write), 32'h1);
    step();
    ev_write_result = 1'b0;
    settle();
    chk("tc_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("tc_no_err", 32'(timeout_err), 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
